mult_acc_sequencer: RTL and testbench

Sequencer that wraps the 8x8 ROM-based multiplier on both sides.
- Buffers incoming operand pairs in a small FIFO.
- Issues each pair to the multiplier with a start pulse and waits for done.
- Accumulates the 16-bit products into a 24-bit sum.
- Presents the sum on a valid/ready output when a pair tagged "last" completes. This gives a dot-product primitive for the datapath.

---
 rtl/mult_acc_sequencer_if.sv | 35 +++
 rtl/mult_acc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mult_acc_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_acc_sequencer_if.sv
// Handshake bundle for mult_acc_sequencer: operand input,
// multiplier side-channel and accumulated-sum output.
interface mult_acc_sequencer_if #(
  parameter int ACC_W = 24
) ();
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             mult_start;
  logic [7:0]       mult_a;
  logic [7:0]       mult_b;
  logic             mult_done;
  logic [15:0]      mult_result;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             err_timeout;

  modport master (
    output in_valid, in_a, in_b, in_last,
    output mult_done, mult_result, out_ready,
    input  in_ready, mult_start, mult_a, mult_b,
    input  out_valid, out_sum, out_ovf, err_timeout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    input  mult_done, mult_result, out_ready,
    output in_ready, mult_start, mult_a, mult_b,
    output out_valid, out_sum, out_ovf, err_timeout
  );
endinterface

// File: rtl/mult_acc_sequencer.sv
// Operand FIFO -> multiplier issue/wait -> 24-bit accumulate,
// sum released on the pair tagged last (dot-product primitive).
module mult_acc_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int ACC_W   = 24
) (
  input logic                clk,
  input logic                rst_n,
  mult_acc_sequencer_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic       last;
    logic [7:0] a;
    logic [7:0] b;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_OUT
  } state_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             push;
  logic             pop;
  entry_t           head;

  state_t           state_q;
  logic             in_ready_q;
  logic             start_q;
  logic             last_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [TW-1:0]    tmo_q;
  logic [15:0]      prod_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W-1:0] sum_q;
  logic             out_ovf_q;
  logic             out_valid_q;
  logic             err_q;
  logic [ACC_W:0]   acc_sum;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (state_q == S_ISSUE);
  assign head = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  assign acc_sum = {1'b0, acc_q}
                 + {{(ACC_W+1-16){1'b0}}, prod_q};

  // Storage needs no reset; occupancy lives in cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {bus.in_last, bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_q       <= wr_q + AW'(push);
      rd_q       <= rd_q + AW'(pop);
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      last_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tmo_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Operands load on entry so they are valid
          // alongside the start pulse.
          if (cnt_q != '0) begin
            state_q <= S_ISSUE;
            start_q <= 1'b1;
            a_q     <= head.a;
            b_q     <= head.b;
            last_q  <= head.last;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mult_done) begin
            prod_q  <= bus.mult_result;
            state_q <= S_ACC;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            prod_q  <= '0;
            err_q   <= 1'b1;
            state_q <= S_ACC;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_ACC: begin
          acc_q <= acc_sum[ACC_W-1:0];
          ovf_q <= ovf_q | acc_sum[ACC_W];
          if (last_q) begin
            sum_q       <= acc_sum[ACC_W-1:0];
            out_ovf_q   <= ovf_q | acc_sum[ACC_W];
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mult_start  = start_q;
  assign bus.mult_a      = a_q;
  assign bus.mult_b      = b_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sum     = sum_q;
  assign bus.out_ovf     = out_ovf_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mult_acc_sequencer.sv
// Randomized bench for mult_acc_sequencer with a multiplier
// stub and a sum-of-products reference model.
module tb_mult_acc_sequencer;

  localparam int ACC_W = 24;
  localparam longint MOD = longint'(1) << ACC_W;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mult_acc_sequencer_if #(.ACC_W(ACC_W)) bus ();

  mult_acc_sequencer #(
    .DEPTH(4), .TIMEOUT(64), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_starts = 0;
  int start_cyc = 0;
  int or_mode = 0;
  int stub_en = 1;
  int stub_rand = 0;
  int stub_t = 1;
  longint cur_total = 0;
  pair_t iss_q[$];
  longint exp_q[$];
  logic [ACC_W-1:0] last_sum = '0;
  logic last_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, longint got, longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic record(logic [7:0] a, logic [7:0] b,
                        logic last);
    pair_t p;
    p.a = a;
    p.b = b;
    iss_q.push_back(p);
    if (stub_en != 0) cur_total += longint'(a) * longint'(b);
    if (last) begin
      exp_q.push_back(cur_total);
      cur_total = 0;
    end
  endtask

  task automatic send(logic [7:0] a, logic [7:0] b,
                      logic last);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_last = last;
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("send_stall", bus.in_ready, 1);
    else record(a, b, last);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic burst(int cycles, int want, output int acc);
    acc = 0;
    repeat (cycles) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a = 8'($urandom_range(1, 255));
      bus.in_b = 8'($urandom_range(1, 255));
      bus.in_last = (acc == want - 1);
      if (bus.in_ready) begin
        record(bus.in_a, bus.in_b, bus.in_last);
        acc++;
      end
    end
    idle(1);
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_out", exp_q.size(), 0);
    chk("drain_iss", iss_q.size(), 0);
  endtask

  // Multiplier stub: done pulses T cycles after start.
  initial begin
    logic [15:0] p;
    int t;
    bus.mult_done = 1'b0;
    bus.mult_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mult_start && stub_en != 0) begin
        p = 16'(bus.mult_a) * 16'(bus.mult_b);
        t = (stub_rand != 0) ? $urandom_range(1, 8) : stub_t;
        repeat (t) @(negedge clk);
        bus.mult_done = 1'b1;
        bus.mult_result = p;
        @(negedge clk);
        bus.mult_done = 1'b0;
        bus.mult_result = 16'($urandom);
      end
    end
  end

  // Output monitor and out_ready driver.
  initial begin
    logic pv;
    logic [ACC_W-1:0] ps;
    logic po;
    logic rd;
    longint tot;
    pair_t e;
    pv = 1'b0;
    ps = '0;
    po = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        bus.out_ready = 1'b0;
        continue;
      end
      if (bus.mult_start) begin
        n_starts++;
        start_cyc = cyc;
        if (iss_q.size() == 0) begin
          chk("spurious_start", bus.mult_start, 0);
        end else begin
          e = iss_q.pop_front();
          chk("mult_a", bus.mult_a, e.a);
          chk("mult_b", bus.mult_b, e.b);
        end
      end
      if (bus.out_valid && pv) begin
        chk("sum_hold", bus.out_sum, ps);
        chk("ovf_hold", bus.out_ovf, po);
      end
      case (or_mode)
        0: rd = 1'b0;
        1: rd = 1'b1;
        default: rd = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rd;
      if (bus.out_valid && rd) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", bus.out_valid, 0);
        end else begin
          tot = exp_q.pop_front();
          chk("out_sum", bus.out_sum, tot % MOD);
          chk("out_ovf", bus.out_ovf, (tot >= MOD) ? 1 : 0);
          last_sum = bus.out_sum;
          last_ovf = bus.out_ovf;
        end
      end
      pv = bus.out_valid && !rd;
      ps = bus.out_sum;
      po = bus.out_ovf;
    end
  end

  initial begin
    int lat;
    int acc;
    int base;
    int n;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_last = 1'b0;

    // Reset values and in_ready timing.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_start", bus.mult_start, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_err", bus.err_timeout, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready0", bus.in_ready, 0);
    @(posedge clk);
    #1 chk("rel_in_ready1", bus.in_ready, 1);

    // Single pair, T=6: latency and hold.
    or_mode = 0;
    stub_t = 6;
    base = n_starts;
    send(8'd3, 8'd5, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (bus.out_valid) break;
    end
    chk("latency", lat, 6 + 3);
    repeat (5) @(negedge clk);
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_sum", bus.out_sum, 15);
    or_mode = 1;
    wait_drain(200);
    chk("one_start", n_starts - base, 1);
    chk("t1_ovf", last_ovf, 0);

    // Three-pair dot product, then restart from zero.
    stub_t = 2;
    send(8'd10, 8'd20, 1'b0);
    send(8'd7, 8'd7, 1'b0);
    send(8'd255, 8'd1, 1'b1);
    idle(1);
    wait_drain(200);
    chk("dot3", last_sum, 504);
    send(8'd1, 8'd1, 1'b1);
    idle(1);
    wait_drain(200);
    chk("restart", last_sum, 1);

    // Done present in the first WAIT cycle.
    stub_t = 1;
    send(8'd9, 8'd11, 1'b1);
    idle(1);
    wait_drain(200);
    chk("t1_fast", last_sum, 99);

    // Wrap: 259 full-scale products, then 258.
    for (int i = 0; i < 259; i++)
      send(8'd255, 8'd255, i == 258);
    idle(1);
    wait_drain(3000);
    chk("wrap_sum", last_sum, 64259);
    chk("wrap_ovf", last_ovf, 1);
    for (int i = 0; i < 258; i++)
      send(8'd255, 8'd255, i == 257);
    idle(1);
    wait_drain(3000);
    chk("nowrap_sum", last_sum, 16776450);
    chk("nowrap_ovf", last_ovf, 0);

    // Multiplier never answers: backpressure and timeout.
    stub_en = 0;
    base = n_starts;
    burst(15, 5, acc);
    chk("to_accepts", acc, 5);
    chk("to_full", bus.in_ready, 0);
    chk("to_one_start", n_starts - base, 1);
    while (cyc < start_cyc + 64) @(negedge clk);
    chk("err_early", bus.err_timeout, 0);
    @(negedge clk);
    chk("err_set", bus.err_timeout, 1);
    wait_drain(1000);
    stub_en = 1;

    // Consumer stalls while more pairs arrive.
    or_mode = 0;
    stub_t = 3;
    send(8'd1, 8'd2, 1'b1);
    idle(1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", bus.out_valid, 1);
    base = n_starts;
    burst(20, 4, acc);
    chk("stall_accepts", acc, 4);
    chk("stall_full", bus.in_ready, 0);
    chk("stall_nostart", n_starts - base, 0);
    chk("stall_sum", bus.out_sum, 2);
    or_mode = 1;
    wait_drain(500);

    // Reset during WAIT with three entries queued.
    stub_t = 20;
    base = n_starts;
    send(8'd9, 8'd9, 1'b0);
    send(8'd8, 8'd8, 1'b0);
    send(8'd7, 8'd7, 1'b0);
    send(8'd6, 8'd6, 1'b1);
    idle(1);
    n = 0;
    while (n_starts == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_in_ready", bus.in_ready, 0);
    chk("mr_start", bus.mult_start, 0);
    chk("mr_a", bus.mult_a, 0);
    chk("mr_b", bus.mult_b, 0);
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_sum", bus.out_sum, 0);
    chk("mr_ovf", bus.out_ovf, 0);
    chk("mr_err", bus.err_timeout, 0);
    iss_q.delete();
    exp_q.delete();
    cur_total = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = n_starts;
    repeat (30) @(negedge clk);
    chk("mr_nostart", n_starts - base, 0);
    chk("mr_noout", bus.out_valid, 0);
    stub_t = 2;
    send(8'd2, 8'd3, 1'b1);
    idle(1);
    wait_drain(200);
    chk("mr_resume", last_sum, 6);

    // Randomized traffic against the model.
    stub_rand = 1;
    or_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0) || (i == 149));
      if ($urandom_range(0, 2) == 0)
        idle($urandom_range(1, 4));
    end
    idle(1);
    wait_drain(5000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
